// File: rtl/alu_arbiter_if.sv
// Handshake and ALU bus for the two-requester ALU arbiter.
// The master side is the environment (requesters, ALU, consumer); the slave side is the arbiter.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_ctrl;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_ctrl;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    output alu_result, alu_zero, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_control,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    input  alu_result, alu_zero, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_control,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: IDLE accepts, EXEC captures the ALU, RESP holds until consumed.
module alu_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          PRIO_RESET = 1'b0
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q;
  logic             prio_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [2:0]       alu_control_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q;
  logic             rsp_err_q;

  logic       grant0, grant1;
  logic       take0, take1;
  logic [2:0] sel_ctrl;
  logic       ctrl_ok;

  always_comb begin
    // A lone requester always wins; on contention the pointer decides.
    grant0   = bus.req0_valid & (~bus.req1_valid | ~prio_q);
    grant1   = bus.req1_valid & (~bus.req0_valid | prio_q);
    take0    = (state_q == StIdle) & grant0;
    take1    = (state_q == StIdle) & grant1;
    sel_ctrl = take1 ? bus.req1_ctrl : bus.req0_ctrl;
    case (sel_ctrl)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: ctrl_ok = 1'b1;
      default:                                ctrl_ok = 1'b0;
    endcase
  end

  assign bus.req0_ready  = take0;
  assign bus.req1_ready  = take1;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_control = alu_control_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_err     = rsp_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      prio_q        <= PRIO_RESET;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_control_q <= 3'b010;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (take0 | take1) begin
            alu_a_q       <= take1 ? bus.req1_a : bus.req0_a;
            alu_b_q       <= take1 ? bus.req1_b : bus.req0_b;
            alu_control_q <= sel_ctrl;
            rsp_id_q      <= take1;
            rsp_err_q     <= ~ctrl_ok;
            state_q       <= StExec;
          end
        end
        StExec: begin
          rsp_result_q <= bus.alu_result;
          rsp_zero_q   <= bus.alu_zero;
          rsp_valid_q  <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            prio_q      <= ~rsp_id_q;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model.
module tb_alu_arbiter;

  localparam bit PRIO = 1'b0;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_arbiter_if #(.WIDTH(32)) bus ();

  alu_arbiter #(
    .WIDTH      (32),
    .PRIO_RESET (PRIO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] c);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return {31'b0, $signed(a) < $signed(b)};
      default: return a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  function automatic bit legal(input logic [2:0] c);
    return c inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
  endfunction

  // Environment ALU driven by the arbiter's registered operands
  assign bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_control);
  assign bus.alu_zero   = (alu_fn(bus.alu_a, bus.alu_b, bus.alu_control) == 32'd0);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction model: at most one accepted op outstanding, response due two cycles after
  // the cycle it was accepted in.
  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
    int          t;
  } txn_t;

  txn_t        q[$];
  bit          m_ptr   = PRIO;
  logic [31:0] m_alu_a = '0;
  logic [31:0] m_alu_b = '0;
  logic [2:0]  m_alu_c = 3'b010;
  int          cyc     = 0;

  always @(negedge clk) begin
    bit          g0, g1, due;
    logic [31:0] er;
    txn_t        t;
    cyc++;
    g0  = (q.size() == 0) && bus.req0_valid && (!bus.req1_valid || m_ptr == 1'b0);
    g1  = (q.size() == 0) && bus.req1_valid && (!bus.req0_valid || m_ptr == 1'b1);
    due = (q.size() != 0) && (cyc >= q[0].t + 2);
    chk("req0_ready", 32'(bus.req0_ready), 32'(g0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(g1));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(due));
    chk("alu_a", bus.alu_a, m_alu_a);
    chk("alu_b", bus.alu_b, m_alu_b);
    chk("alu_control", 32'(bus.alu_control), 32'(m_alu_c));
    if (due) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
      chk("rsp_err", 32'(bus.rsp_err), 32'(!legal(q[0].c)));
      if (legal(q[0].c)) begin
        er = alu_fn(q[0].a, q[0].b, q[0].c);
        chk("rsp_result", bus.rsp_result, er);
        chk("rsp_zero", 32'(bus.rsp_zero), 32'(er == 32'd0));
      end
    end
    if (reset) begin
      q.delete();
      m_ptr   = PRIO;
      m_alu_a = '0;
      m_alu_b = '0;
      m_alu_c = 3'b010;
    end else if (due && bus.rsp_ready) begin
      m_ptr = !q[0].id;
      void'(q.pop_front());
    end else if (g0 || g1) begin
      t.id = g1;
      t.a  = g1 ? bus.req1_a : bus.req0_a;
      t.b  = g1 ? bus.req1_b : bus.req0_b;
      t.c  = g1 ? bus.req1_ctrl : bus.req0_ctrl;
      t.t  = cyc;
      q.push_back(t);
      m_alu_a = t.a;
      m_alu_b = t.b;
      m_alu_c = t.c;
    end
  end

  task automatic set_req(input bit id, input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c);
    if (id) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = c;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = c;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_ready(input bit id, output bit got);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = id ? bus.req1_ready : bus.req0_ready;
    end
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] c, input int hold, input logic [31:0] er,
                       input bit ez, input bit ee);
    bit got;
    @(posedge clk); #1 set_req(id, 1'b1, a, b, c);
    wait_ready(id, got);
    @(posedge clk); #1 set_req(id, 1'b0, '0, '0, 3'b000);
    if (!got) return;
    @(negedge clk); chk("lat_exec", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk); chk("lat_resp", 32'(bus.rsp_valid), 32'd1);
    chk("d_rsp_id", 32'(bus.rsp_id), 32'(id));
    chk("d_rsp_err", 32'(bus.rsp_err), 32'(ee));
    if (!ee) begin
      chk("d_rsp_result", bus.rsp_result, er);
      chk("d_rsp_zero", 32'(bus.rsp_zero), 32'(ez));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      if (!ee) chk("hold_result", bus.rsp_result, er);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    @(negedge clk); chk("consumed", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic rand_step(input bit id, input bit took);
    logic [31:0] a, b;
    logic [2:0]  c;
    bit          v;
    v = id ? bus.req1_valid : bus.req0_valid;
    if (v && !took && $urandom_range(7) != 0) return;
    a = ($urandom_range(3) == 0) ? 32'($urandom_range(15)) : $urandom;
    b = ($urandom_range(3) == 0) ? a : $urandom;
    c = ($urandom_range(5) == 0) ? 3'($urandom_range(5, 3)) : 3'($urandom);
    if (c inside {3'b011, 3'b100, 3'b101} && $urandom_range(1) == 0) c = 3'b110;
    set_req(id, 1'($urandom_range(1)), a, b, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    bit got, r0, r1;
    int ids[$];
    reset = 1'b1;
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 1'b0, '0, '0, 3'b000);
    set_req(1'b1, 1'b0, '0, '0, 3'b000);

    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_alu_control", 32'(bus.alu_control), 32'd2);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    do_op(1'b0, 32'd5, 32'd7, 3'b010, 0, 32'd12, 1'b0, 1'b0);
    do_op(1'b0, 32'd9, 32'd9, 3'b110, 4, 32'd0, 1'b1, 1'b0);

    // Both requesters valid continuously: grants must alternate from the reset pointer
    pulse_reset();
    bus.rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, 32'd1, 32'd2, 3'b010);
    set_req(1'b1, 1'b1, 32'd3, 32'd4, 3'b001);
    for (int k = 0; k < 40 && ids.size() < 4; k++) begin
      @(negedge clk);
      if (bus.req0_ready) ids.push_back(0);
      if (bus.req1_ready) ids.push_back(1);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, '0, '0, 3'b000);
    set_req(1'b1, 1'b0, '0, '0, 3'b000);
    chk("rr_count", 32'(ids.size()), 32'd4);
    for (int i = 0; i < ids.size(); i++) chk("rr_grant", 32'(ids[i]), 32'(i % 2));
    repeat (4) @(posedge clk);
    #1 bus.rsp_ready = 1'b0;

    do_op(1'b1, 32'd4, 32'd2, 3'b011, 0, 32'd0, 1'b0, 1'b1);
    do_op(1'b1, 32'd4, 32'd2, 3'b010, 0, 32'd6, 1'b0, 1'b0);

    // Reset during EXEC after a req0 op has moved the pointer to 1
    do_op(1'b0, 32'd1, 32'd2, 3'b010, 0, 32'd3, 1'b0, 1'b0);
    @(posedge clk); #1 set_req(1'b0, 1'b1, 32'd10, 32'd20, 3'b010);
    wait_ready(1'b0, got);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, '0, '0, 3'b000);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_alu_control", 32'(bus.alu_control), 32'd2);
    repeat (3) begin
      @(negedge clk); chk("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 32'd1, 32'd1, 3'b010);
    set_req(1'b1, 1'b1, 32'd1, 32'd1, 3'b010);
    @(negedge clk);
    chk("mid_rst_ptr0", 32'(bus.req0_ready), 32'd1);
    chk("mid_rst_ptr1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, '0, '0, 3'b000);
    set_req(1'b1, 1'b0, '0, '0, 3'b000);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;

    do_op(1'b1, 32'd3, 32'd8, 3'b111, 0, 32'd1, 1'b0, 1'b0);
    do_op(1'b0, 32'hF0, 32'h0F, 3'b000, 0, 32'd0, 1'b1, 1'b0);

    // Random traffic, checked by the model process
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      r0 = bus.req0_ready;
      r1 = bus.req1_ready;
      @(posedge clk); #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(63) == 0) reset = 1'b1;
      rand_step(1'b0, r0);
      rand_step(1'b1, r1);
      bus.rsp_ready = ($urandom_range(2) != 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    set_req(1'b0, 1'b0, '0, '0, 3'b000);
    set_req(1'b1, 1'b0, '0, '0, 3'b000);
    bus.rsp_ready = 1'b1;
    repeat (6) @(posedge clk);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
